// File: rtl/vproc_arb_pkg.sv
// Shared types and constants for the VProc memory-port arbiter.
package vproc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } arb_state_e;

    localparam int         DATA_WIDTH = 32;
    localparam logic [3:0] BE_ALL     = 4'hf;

    // Width of a node index; never below one bit so a degenerate index bus stays legal.
    function automatic int idx_width(input int num_nodes);
        return (num_nodes > 1) ? $clog2(num_nodes) : 1;
    endfunction

endpackage

// File: rtl/vproc_rr_arbiter.sv
// Combinational round-robin pick: first requesting node at or after rr_ptr, wrapping.
module vproc_rr_arbiter
    import vproc_arb_pkg::*;
#(
    parameter  int NUM_NODES = 2,
    localparam int IDX_W     = idx_width(NUM_NODES)
) (
    input  logic [NUM_NODES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 gnt_valid,
    output logic [IDX_W-1:0]     gnt_idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Walk offsets from farthest to nearest; the nearest requester overwrites last.
        for (int k = NUM_NODES - 1; k >= 0; k--) begin
            int node;
            node = (int'(rr_ptr) + k) % NUM_NODES;
            if (req[node]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(node);
            end
        end
    end

endmodule

// File: rtl/vproc_mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle memory port between NUM_NODES VProc nodes.
module vproc_mem_arbiter
    import vproc_arb_pkg::*;
#(
    parameter  int NUM_NODES  = 2,
    parameter  int LOG2WORDS  = 14,
    parameter  int ADDR_WIDTH = 32,
    localparam int IDX_W      = idx_width(NUM_NODES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_NODES-1:0]             req_we,
    input  logic [NUM_NODES-1:0]             req_rd,
    input  logic [NUM_NODES*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_NODES*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_NODES-1:0]             req_wrack,
    output logic [NUM_NODES-1:0]             req_rdack,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             mem_cs,
    output logic                             mem_we,
    output logic [3:0]                       mem_be,
    output logic [LOG2WORDS-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             grant_valid,
    output logic [IDX_W-1:0]                 grant_idx
);

    arb_state_e state, state_nx;

    logic [NUM_NODES-1:0]  req;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [LOG2WORDS-1:0]  pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_q;
    logic                  op_we_q;
    logic [LOG2WORDS-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_NODES-1:0]  wrack_q;
    logic [NUM_NODES-1:0]  rdack_q;

    assign req = req_we | req_rd;

    vproc_rr_arbiter #(
        .NUM_NODES (NUM_NODES)
    ) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // Byte address to word address: drop bits [1:0] and everything above the memory size.
    assign pick_addr  = req_addr[int'(pick_idx)*ADDR_WIDTH + 2 +: LOG2WORDS];
    assign pick_wdata = req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];

    // mem_cs decodes the async-reset state, so reset drops an in-flight access at once.
    always_comb begin
        state_nx = state;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        case (state)
            IDLE:    if (pick_valid) state_nx = ISSUE;
            ISSUE: begin
                mem_cs   = 1'b1;
                mem_we   = op_we_q;
                state_nx = ACK;
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            op_we_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wrack_q <= '0;
            rdack_q <= '0;
        end else begin
            state   <= state_nx;
            wrack_q <= '0;
            rdack_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        op_we_q <= req_we[pick_idx];
                        addr_q  <= pick_addr;
                        wdata_q <= pick_wdata;
                    end
                end
                ISSUE: begin
                    if (op_we_q) wrack_q[grant_q] <= 1'b1;
                    else         rdack_q[grant_q] <= 1'b1;
                end
                ACK: begin
                    rr_ptr <= (grant_q == IDX_W'(NUM_NODES - 1)) ? '0 : grant_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_wrack   = wrack_q;
    assign req_rdack   = rdack_q;
    assign req_rdata   = (|rdack_q) ? mem_rdata : '0;
    assign mem_be      = BE_ALL;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_valid = (state != IDLE);
    assign grant_idx   = grant_q;

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// Randomised scoreboard bench for vproc_mem_arbiter with a behavioural memory and arbitration model.
module tb_vproc_mem_arbiter;

    localparam int NODES = 4;
    localparam int LW    = 14;
    localparam int AW    = 32;
    localparam int IW    = 2;

    typedef struct {
        int          node;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic                  clk;
    logic                  rst_n;
    logic [NODES-1:0]      req_we;
    logic [NODES-1:0]      req_rd;
    logic [NODES*AW-1:0]   req_addr;
    logic [NODES*32-1:0]   req_wdata;
    logic [NODES-1:0]      req_wrack;
    logic [NODES-1:0]      req_rdack;
    logic [31:0]           req_rdata;
    logic                  mem_cs;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [LW-1:0]         mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  grant_valid;
    logic [IW-1:0]         grant_idx;

    vproc_mem_arbiter #(
        .NUM_NODES  (NODES),
        .LOG2WORDS  (LW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_we      (req_we),
        .req_rd      (req_rd),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wrack   (req_wrack),
        .req_rdack   (req_rdack),
        .req_rdata   (req_rdata),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory port model: single-cycle synchronous, read data valid the cycle after cs.
    logic [31:0] mem [0:(1<<LW)-1];
    int          mem_writes = 0;
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_writes    <= mem_writes + 1;
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    txn_t        exp_q[$];
    logic [31:0] ref_mem [int];
    int          ack_cnt [NODES];
    int          wr_cnt  [NODES];
    int          rd_cnt  [NODES];
    int          rel_cnt [NODES];
    bit          busy    [NODES];
    int          ack_log[$];
    int          ack_cyc[$];
    int          model_ptr = 0;
    int          cycle = 0;
    logic [31:0] last_rdata = '0;
    logic [LW-1:0] last_issue_addr = '0;
    logic        last_issue_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [NODES-1:0] r, input int ptr);
        for (int k = 0; k < NODES; k++)
            if (r[(ptr + k) % NODES]) return (ptr + k) % NODES;
        return -1;
    endfunction

    function automatic int find_txn(input int n);
        foreach (exp_q[k]) if (exp_q[k].node == n) return k;
        return -1;
    endfunction

    // Monitor: predicts grants from the round-robin rule and retires scoreboard entries on acks.
    initial begin : monitor
        bit          prev_gv;
        bit          in_ack;
        int          exp_idx;
        int          k;
        txn_t        cur;
        logic [NODES-1:0] reqv;
        logic [NODES-1:0] acks;
        prev_gv = 1'b0;
        in_ack  = 1'b0;
        exp_idx = 0;
        cur     = '{node: 0, we: 1'b0, addr: '0, wdata: '0};
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (!rst_n) begin
                prev_gv   = 1'b0;
                in_ack    = 1'b0;
                model_ptr = 0;
                continue;
            end
            reqv = req_we | req_rd;
            acks = req_wrack | req_rdack;
            check("ack_exclusive", 32'($countones(acks) <= 1 && (req_wrack & req_rdack) == '0), 1);
            if (in_ack) begin
                in_ack = 1'b0;
                check("ack_grant_valid", grant_valid, 1);
                check("ack_grant_idx", grant_idx, exp_idx);
                check("wrack", req_wrack, cur.we ? (32'd1 << exp_idx) : 32'd0);
                check("rdack", req_rdack, cur.we ? 32'd0 : (32'd1 << exp_idx));
                if (cur.we) begin
                    ref_mem[int'(cur.addr[LW+1:2])] = cur.wdata;
                end else begin
                    if (ref_mem.exists(int'(cur.addr[LW+1:2])))
                        check("rdata", req_rdata, ref_mem[int'(cur.addr[LW+1:2])]);
                    last_rdata = req_rdata;
                end
                k = find_txn(exp_idx);
                if (k >= 0) exp_q.delete(k);
                ack_cnt[exp_idx]++;
                if (cur.we) wr_cnt[exp_idx]++;
                else        rd_cnt[exp_idx]++;
                ack_log.push_back(exp_idx);
                ack_cyc.push_back(cycle);
                model_ptr = (exp_idx + 1) % NODES;
            end else begin
                check("no_ack", acks, 0);
                if (!prev_gv) begin
                    check("issue_on_req", mem_cs, 32'(reqv != '0));
                    if (reqv != '0) begin
                        exp_idx = model_pick(reqv, model_ptr);
                        check("grant_valid", grant_valid, 1);
                        check("grant_idx", grant_idx, exp_idx);
                        k = find_txn(exp_idx);
                        check("grant_has_txn", 32'(k >= 0), 1);
                        if (k >= 0) cur = exp_q[k];
                        else cur = '{node: exp_idx, we: req_we[exp_idx], addr: '0, wdata: '0};
                        check("mem_we", mem_we, cur.we);
                        check("mem_addr", mem_addr, cur.addr[LW+1:2]);
                        check("mem_be", mem_be, 4'hf);
                        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                        last_issue_addr = mem_addr;
                        last_issue_we   = mem_we;
                        in_ack = 1'b1;
                    end
                end else begin
                    check("idle_after_ack", 32'({grant_valid, mem_cs}), 0);
                end
            end
            prev_gv = grant_valid;
        end
    end

    // Stimulus helpers: strobes change only on the falling edge; a node drops its strobe once acked.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NODES; i++) begin
            if (rel_cnt[i] != ack_cnt[i]) begin
                rel_cnt[i] = ack_cnt[i];
                req_we[i]  = 1'b0;
                req_rd[i]  = 1'b0;
                busy[i]    = 1'b0;
            end
        end
    endtask

    task automatic start(input int n, input bit we, input bit rd, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        req_we[n]              = we;
        req_rd[n]              = rd;
        req_addr[n*AW +: AW]   = a;
        req_wdata[n*32 +: 32]  = d;
        busy[n]                = 1'b1;
        t = '{node: n, we: we, addr: a, wdata: d};
        exp_q.push_back(t);
    endtask

    task automatic wait_idle(input int n);
        int budget;
        budget = 60;
        while (busy[n] && budget > 0) begin
            tick();
            budget--;
        end
        if (busy[n]) check("wait_timeout", 32'(n), 32'hffff_ffff);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_we = '0;
        req_rd = '0;
        exp_q.delete();
        for (int i = 0; i < NODES; i++) begin
            busy[i]    = 1'b0;
            rel_cnt[i] = ack_cnt[i];
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] node_addr(input int n, input logic [3:0] w);
        logic [LW-1:0] word;
        word = {2'(n), 8'h00, w};
        return {16'($urandom), word, 2'($urandom)};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int snap;
        int issued [NODES];
        int budget;
        int r;
        rst_n     = 1'b0;
        req_we    = '0;
        req_rd    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NODES; i++) begin
            ack_cnt[i] = 0; wr_cnt[i] = 0; rd_cnt[i] = 0; rel_cnt[i] = 0; busy[i] = 1'b0;
        end
        tick();
        tick();
        check("rst_mem_cs", mem_cs, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 4'hf);
        check("rst_grant", 32'({grant_valid, grant_idx}), 0);
        check("rst_acks", 32'({req_wrack, req_rdack}), 0);
        check("rst_rdata", req_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        tick();

        // Single write then read from node 0.
        start(0, 1'b1, 1'b0, 32'h0000_0010, 32'hdeadbeef);
        wait_idle(0);
        check("t1_issue_addr", last_issue_addr, 14'h4);
        check("t1_issue_we", last_issue_we, 1);
        check("t1_wrack_cnt", wr_cnt[0], 1);
        start(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        wait_idle(0);
        check("t1_rdata", last_rdata, 32'hdeadbeef);
        check("t1_rdack_cnt", rd_cnt[0], 1);

        // Contention from reset: node 0 first, acks three cycles apart.
        apply_reset();
        base = ack_log.size();
        start(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
        start(1, 1'b0, 1'b1, 32'h0000_4020, 32'h0);
        wait_idle(0);
        wait_idle(1);
        if (ack_log.size() >= base + 2) begin
            check("cont_first", ack_log[base], 0);
            check("cont_second", ack_log[base+1], 1);
            check("cont_spacing", ack_cyc[base+1] - ack_cyc[base], 3);
        end else check("cont_ack_count", ack_log.size() - base, 2);

        // Write and read strobes together count as a write.
        snap = mem_writes;
        r    = rd_cnt[1];
        start(1, 1'b1, 1'b1, 32'h0000_4014, 32'h1234_5678);
        wait_idle(1);
        tick();
        check("both_mem_writes", mem_writes - snap, 1);
        check("both_no_rdack", rd_cnt[1], r);
        check("both_mem_word", mem[14'h1005], 32'h1234_5678);

        // Strobe pulsed by node 2 while node 0 is being served is never granted.
        snap = ack_cnt[2];
        start(0, 1'b1, 1'b0, 32'h0000_0030, 32'hcafe_0001);
        budget = 20;
        while (!grant_valid && budget > 0) begin tick(); budget--; end
        check("wd_granted", grant_valid, 1);
        req_rd[2] = 1'b1;
        tick();
        req_rd[2] = 1'b0;
        wait_idle(0);
        repeat (5) tick();
        check("wd_no_node2", ack_cnt[2], snap);

        // Reset during ISSUE of a write: no ack, memory untouched, FSM back in IDLE.
        start(0, 1'b1, 1'b0, 32'h0000_0020, 32'ha5a5_0001);
        wait_idle(0);
        snap = ack_cnt[0];
        start(0, 1'b1, 1'b0, 32'h0000_0020, 32'h5a5a_ffff);
        budget = 20;
        while (!mem_cs && budget > 0) begin tick(); budget--; end
        check("rst_issue_seen", mem_cs, 1);
        rst_n = 1'b0;
        #1;
        check("rst_issue_cs", mem_cs, 0);
        req_we = '0;
        req_rd = '0;
        exp_q.delete();
        for (int i = 0; i < NODES; i++) busy[i] = 1'b0;
        tick();
        tick();
        check("rst_issue_noack", ack_cnt[0], snap);
        check("rst_issue_mem", mem[14'h8], 32'ha5a5_0001);
        rst_n = 1'b1;
        tick();
        check("rst_issue_idle", grant_valid, 0);
        check("rst_issue_gidx", grant_idx, 0);
        start(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
        wait_idle(0);
        check("rst_issue_rdback", last_rdata, 32'ha5a5_0001);

        // Fairness: four nodes requesting continuously for 40 transactions.
        apply_reset();
        base = ack_log.size();
        for (int i = 0; i < NODES; i++) begin
            issued[i] = 0;
            snap      = ack_cnt[i];
            rel_cnt[i] = snap;
        end
        for (int i = 0; i < NODES; i++) ack_cnt[i] = ack_cnt[i];
        budget = 400;
        while (budget > 0) begin
            for (int i = 0; i < NODES; i++) begin
                if (!busy[i] && issued[i] < 10) begin
                    start(i, 1'b0, 1'b1, node_addr(i, 4'($urandom)), 32'h0);
                    issued[i]++;
                end
            end
            if (!busy[0] && !busy[1] && !busy[2] && !busy[3] &&
                issued[0] == 10 && issued[1] == 10 && issued[2] == 10 && issued[3] == 10) break;
            tick();
            budget--;
        end
        check("fair_done", 32'(ack_log.size() - base), 40);
        for (int n = 0; n < NODES; n++) begin
            int cnt;
            cnt = 0;
            for (int k = base; k < ack_log.size(); k++) if (ack_log[k] == n) cnt++;
            check("fair_count", cnt, 10);
        end
        for (int k = 0; k < 40 && base + k < ack_log.size(); k++)
            check("fair_order", ack_log[base+k], k % NODES);

        // Random mix of reads, writes and dual strobes in per-node address regions.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < NODES; i++) begin
                if (!busy[i] && ($urandom % 3) == 0) begin
                    r = int'($urandom % 4);
                    start(i, r >= 2, r != 2, node_addr(i, 4'($urandom)), $urandom);
                end
            end
            tick();
        end
        for (int i = 0; i < NODES; i++) wait_idle(i);
        check("rand_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
